// File: rtl/contador_decadico_crescente_pkg.sv
// Shared BCD constants and nibble helpers for the decade up-counter.
package contador_decadico_crescente_pkg;

  localparam int              BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // True when the nibble is a legal decimal digit.
  function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

  // Legal digits pass through; A-F collapse to 0 so no illegal value is ever stored.
  function automatic logic [BCD_W-1:0] sanitize_bcd(input logic [BCD_W-1:0] nibble);
    return is_bcd(nibble) ? nibble : '0;
  endfunction

endpackage

// File: rtl/contador_decadico_crescente_bcd_digit_up.sv
// One BCD digit of the up-counter: load, increment with 9->0 rollover, or hold.
module bcd_digit_up
  import contador_decadico_crescente_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] ld_nibble,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             is_nine
);

  // Digit register: load has priority over increment; clear zeroes it asynchronously.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q <= '0;
    end else if (load) begin
      q <= sanitize_bcd(ld_nibble);
    end else if (inc) begin
      q <= (q == BCD_MAX) ? '0 : q + BCD_W'(1);
    end
  end

  assign is_nine = (q == BCD_MAX);

endmodule

// File: rtl/contador_decadico_crescente.sv
// Synchronous multi-digit BCD up-counter with preset load, cascade carry,
// wrap pulse and invalid-load pulse. All digits are clocked by clk.
module contador_decadico_crescente
  import contador_decadico_crescente_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    terminal,
  output logic                    carry_out,
  output logic                    wrap,
  output logic                    load_error
);

  logic [DIGITS-1:0] is_nine;
  logic              count_en;
  logic              any_invalid;

  // Load overrides counting, so an increment is only requested when not loading.
  assign count_en = enable & ~load;

  // Digit i advances when counting and every lower digit is 9 (parallel carry, no ripple clock).
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic digit_inc;
    if (gi == 0) begin : g_lsd
      assign digit_inc = count_en;
    end else begin : g_upper
      assign digit_inc = count_en & (&is_nine[gi-1:0]);
    end

    bcd_digit_up u_digit (
      .clk       (clk),
      .clear     (clear),
      .load      (load),
      .ld_nibble (load_value[gi*BCD_W +: BCD_W]),
      .inc       (digit_inc),
      .q         (bcd[gi*BCD_W +: BCD_W]),
      .is_nine   (is_nine[gi])
    );
  end

  assign terminal  = &is_nine;
  assign carry_out = terminal & count_en;

  // Flag a load value containing any nibble above 9.
  // NOTE: the default before the loop keeps this purely combinational (no latch).
  always_comb begin
    any_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(load_value[i*BCD_W +: BCD_W])) any_invalid = 1'b1;
    end
  end

  // Single-cycle status pulses, recomputed every edge so they never stick.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wrap       <= 1'b0;
      load_error <= 1'b0;
    end else begin
      wrap       <= count_en & terminal;
      load_error <= load & any_invalid;
    end
  end

endmodule

// File: tb/tb_contador_decadico_crescente.sv
// Scoreboard bench for the BCD up-counter: a driver applies stimulus on the
// falling edge and queues the expected post-edge state from an integer model;
// a monitor pops and compares after each rising edge.
module tb_contador_decadico_crescente;

  localparam int D   = 2;
  localparam int W   = 4 * D;
  localparam int MAX = 99;   // 10**D - 1

  typedef struct {
    logic [W-1:0] bcd;
    logic         wrap;
    logic         lerr;
  } exp_t;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] bcd;
  logic         terminal, carry_out, wrap, load_error;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: counter value as a plain integer plus the pulse flags.
  int   cur_val = 0;
  logic cur_wrap = 1'b0;
  logic cur_lerr = 1'b0;

  contador_decadico_crescente #(.DIGITS(D)) dut (
    .clk        (clk),
    .clear      (clear),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .bcd        (bcd),
    .terminal   (terminal),
    .carry_out  (carry_out),
    .wrap       (wrap),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] int_to_bcd(input int n);
    logic [W-1:0] r;
    int v;
    r = '0;
    v = n;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Decimal value a load produces: illegal digits count as 0.
  function automatic int load_to_int(input logic [W-1:0] lv);
    int n, scale;
    logic [3:0] nib;
    n = 0;
    scale = 1;
    for (int i = 0; i < D; i++) begin
      nib = lv[i*4 +: 4];
      n += ((nib > 4'd9) ? 0 : int'(nib)) * scale;
      scale *= 10;
    end
    return n;
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] lv);
    logic [3:0] nib;
    for (int i = 0; i < D; i++) begin
      nib = lv[i*4 +: 4];
      if (nib > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock of stimulus: drive on the falling edge, check combinational
  // outputs against the current model value, then queue the next state.
  task automatic step(input logic cl, input logic ld, input logic en, input logic [W-1:0] lv);
    int nxt;
    logic nw, nle;
    @(negedge clk);
    clear = cl; load = ld; enable = en; load_value = lv;
    #1;
    if (cl) begin
      check("terminal",  32'(terminal),  32'(cur_val == MAX));
      check("carry_out", 32'(carry_out), 32'((cur_val == MAX) && en && !ld));
    end
    nxt = cur_val; nw = 1'b0; nle = 1'b0;
    if (!cl) begin
      nxt = 0;
    end else if (ld) begin
      nxt = load_to_int(lv);
      nle = has_bad_digit(lv);
    end else if (en) begin
      nxt = (cur_val + 1) % (MAX + 1);
      nw  = (cur_val == MAX);
    end
    cur_val = nxt; cur_wrap = nw; cur_lerr = nle;
    q_exp.push_back('{bcd: int_to_bcd(nxt), wrap: nw, lerr: nle});
  endtask

  // Monitor: compare the DUT against the oldest queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        check("bcd",        32'(bcd),        32'(e.bcd));
        check("wrap",       32'(wrap),       32'(e.wrap));
        check("load_error", 32'(load_error), 32'(e.lerr));
      end
    end
  end

  initial begin
    // Async reset with enable high: outputs zero before any edge.
    enable = 1'b1;
    #1 clear = 1'b0;
    #1;
    check("reset_bcd",  32'(bcd),        32'h0);
    check("reset_wrap", 32'(wrap),       32'h0);
    check("reset_lerr", 32'(load_error), 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b1, '0);

    // Release: first edge increments to 01, then a full lap through 99 and wrap.
    step(1'b1, 1'b0, 1'b1, '0);
    repeat (100) step(1'b1, 1'b0, 1'b1, '0);

    // Preset and count on.
    step(1'b1, 1'b1, 1'b0, 8'h47);
    repeat (5) step(1'b1, 1'b0, 1'b1, '0);

    // Illegal digits load as 0 and raise a one-cycle error pulse.
    step(1'b1, 1'b1, 1'b0, 8'hA3);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 8'hFF);
    step(1'b1, 1'b0, 1'b0, '0);

    // Load beats enable at 99: no wrap, carry_out low.
    step(1'b1, 1'b1, 1'b0, 8'h99);
    step(1'b1, 1'b1, 1'b1, 8'h12);
    step(1'b1, 1'b0, 1'b0, '0);

    // Clear between edges at 58 zeroes the outputs without a clock edge.
    step(1'b1, 1'b1, 1'b0, 8'h58);
    @(negedge clk);
    clear = 1'b1; load = 1'b0; enable = 1'b1;
    #2 clear = 1'b0;
    #1;
    check("async_bcd",  32'(bcd),        32'h0);
    check("async_wrap", 32'(wrap),       32'h0);
    check("async_lerr", 32'(load_error), 32'h0);
    cur_val = 0; cur_wrap = 1'b0; cur_lerr = 1'b0;
    q_exp.push_back('{bcd: '0, wrap: 1'b0, lerr: 1'b0});
    step(1'b0, 1'b0, 1'b0, '0);
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);

    // Randomized mix of load, enable and hold.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [W-1:0] lv;
      r  = int'($urandom_range(0, 9));
      lv = W'($urandom);
      step(1'b1, r == 0, r < 7, lv);
    end

    step(1'b1, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 32'(q_exp.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
